// File: rtl/dfl_axis_tx_pkg.sv
// Shared widths and the hold-slot entry type for the dataflow-to-AXI4-Stream transmitter.
package dfl_axis_tx_pkg;

    localparam int N_FIELDS   = 8;
    localparam int FIELD_BITS = 64;
    localparam int AXI_DATA_W = N_FIELDS * FIELD_BITS;
    localparam int AXI_KEEP_W = AXI_DATA_W / 8;
    localparam int IDX_W      = 16;
    localparam int CNT_W      = 32;

    typedef struct packed {
        logic                  valid;
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
    } hold_entry_t;

endpackage

// File: rtl/dfl_axis_tx.sv
// Dataflow beat/token stream to AXI4-Stream. A one-entry hold slot delays each beat until
// the next data beat or end-of-stream token reveals whether it closes a packet.
module dfl_axis_tx #(
    parameter int N_FIELDS   = 8,
    parameter int FIELD_BITS = 64
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [15:0]                    cfg_pkt_beats,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FIELD_BITS-1:0]          in_data_field0,
    input  logic [FIELD_BITS-1:0]          in_data_field1,
    input  logic [FIELD_BITS-1:0]          in_data_field2,
    input  logic [FIELD_BITS-1:0]          in_data_field3,
    input  logic [FIELD_BITS-1:0]          in_data_field4,
    input  logic [FIELD_BITS-1:0]          in_data_field5,
    input  logic [FIELD_BITS-1:0]          in_data_field6,
    input  logic [FIELD_BITS-1:0]          in_data_field7,
    input  logic                           in_ctrl_valid,
    output logic                           in_ctrl_ready,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [N_FIELDS*FIELD_BITS-1:0] m_axis_tdata,
    output logic [N_FIELDS*FIELD_BITS/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [31:0]                    cnt_beats,
    output logic [31:0]                    cnt_pkts
);
    import dfl_axis_tx_pkg::*;

    logic [FIELD_BITS-1:0]   in_fields [N_FIELDS];
    logic [AXI_DATA_W-1:0]   in_data_cat;

    hold_entry_t             hold_reg, hold_next;
    logic [IDX_W-1:0]        beat_idx_reg, beat_idx_next;
    logic [IDX_W-1:0]        cfg_lat_reg, cfg_lat_next;
    logic                    tvalid_reg, tvalid_next;
    logic [AXI_DATA_W-1:0]   tdata_reg, tdata_next;
    logic                    tlast_reg, tlast_next;
    logic [CNT_W-1:0]        cnt_beats_reg, cnt_pkts_reg;

    logic                    out_free;
    logic                    data_acc, ctrl_acc;
    logic [IDX_W-1:0]        cfg_eff, beat_inc;
    logic                    new_last;
    logic                    load_out, load_last;

    assign in_fields[0] = in_data_field0;
    assign in_fields[1] = in_data_field1;
    assign in_fields[2] = in_data_field2;
    assign in_fields[3] = in_data_field3;
    assign in_fields[4] = in_data_field4;
    assign in_fields[5] = in_data_field5;
    assign in_fields[6] = in_data_field6;
    assign in_fields[7] = in_data_field7;

    generate
        for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_pack
            assign in_data_cat[gi*FIELD_BITS +: FIELD_BITS] = in_fields[gi];
        end
    endgenerate

    // Gating with aresetn keeps both ready outputs low for the whole reset interval.
    assign out_free      = ~tvalid_reg | m_axis_tready;
    assign in_ready      = aresetn & out_free;
    assign in_ctrl_ready = aresetn & out_free & ~in_valid;
    assign data_acc      = in_valid & in_ready;
    assign ctrl_acc      = in_ctrl_valid & in_ctrl_ready;

    // The packet length is sampled on the first beat of each packet.
    assign cfg_eff  = (beat_idx_reg == '0) ? cfg_pkt_beats : cfg_lat_reg;
    assign beat_inc = beat_idx_reg + 16'd1;
    assign new_last = (cfg_eff != '0) && (beat_inc == cfg_eff);

    always_comb begin
        hold_next     = hold_reg;
        beat_idx_next = beat_idx_reg;
        cfg_lat_next  = cfg_lat_reg;
        load_out      = 1'b0;
        load_last     = 1'b0;
        tvalid_next   = tvalid_reg & ~m_axis_tready;
        tdata_next    = tdata_reg;
        tlast_next    = tlast_reg;

        if (data_acc) begin
            if (beat_idx_reg == '0) begin
                cfg_lat_next = cfg_pkt_beats;
            end
            beat_idx_next = new_last ? '0 : beat_inc;
            if (hold_reg.valid) begin
                load_out  = 1'b1;
                load_last = hold_reg.last;
            end
            hold_next = '{valid: 1'b1, data: in_data_cat, last: new_last};
        end else if (ctrl_acc) begin
            beat_idx_next = '0;
            if (hold_reg.valid) begin
                load_out  = 1'b1;
                load_last = 1'b1;
            end
            hold_next.valid = 1'b0;
        end else if (out_free && hold_reg.valid && hold_reg.last) begin
            // A packet-closing beat needs no look-ahead, so flush it immediately.
            load_out        = 1'b1;
            load_last       = 1'b1;
            hold_next.valid = 1'b0;
        end

        if (load_out) begin
            tvalid_next = 1'b1;
            tdata_next  = hold_reg.data;
            tlast_next  = load_last;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hold_reg      <= '0;
            beat_idx_reg  <= '0;
            cfg_lat_reg   <= '0;
            tvalid_reg    <= 1'b0;
            tdata_reg     <= '0;
            tlast_reg     <= 1'b0;
            cnt_beats_reg <= '0;
            cnt_pkts_reg  <= '0;
        end else begin
            hold_reg      <= hold_next;
            beat_idx_reg  <= beat_idx_next;
            cfg_lat_reg   <= cfg_lat_next;
            tvalid_reg    <= tvalid_next;
            tdata_reg     <= tdata_next;
            tlast_reg     <= tlast_next;
            if (tvalid_reg && m_axis_tready) begin
                cnt_beats_reg <= cnt_beats_reg + 32'd1;
                if (tlast_reg) begin
                    cnt_pkts_reg <= cnt_pkts_reg + 32'd1;
                end
            end
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tkeep  = '1;
    assign cnt_beats     = cnt_beats_reg;
    assign cnt_pkts      = cnt_pkts_reg;

endmodule

// File: tb/tb_dfl_axis_tx.sv
// Randomized and directed bench for dfl_axis_tx against a packet-level stream model.
module tb_dfl_axis_tx;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [15:0]  cfg_pkt_beats;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  f [8];
    logic         in_ctrl_valid;
    logic         in_ctrl_ready;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [31:0]  cnt_beats;
    logic [31:0]  cnt_pkts;

    always #5 aclk = ~aclk;

    dfl_axis_tx dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_pkt_beats(cfg_pkt_beats),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data_field0(f[0]), .in_data_field1(f[1]), .in_data_field2(f[2]), .in_data_field3(f[3]),
        .in_data_field4(f[4]), .in_data_field5(f[5]), .in_data_field6(f[6]), .in_data_field7(f[7]),
        .in_ctrl_valid(in_ctrl_valid), .in_ctrl_ready(in_ctrl_ready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .cnt_beats(cnt_beats), .cnt_pkts(cnt_pkts)
    );

    int checks = 0;
    int failures = 0;

    // Stream model: accepted beats in order, each tagged with whether it ends a packet.
    logic [511:0] exp_data[$];
    bit           exp_last[$];
    bit           open_tail;
    int           pkt_cnt, pkt_cfg;
    logic [31:0]  mdl_beats, mdl_pkts;
    logic [63:0]  obs_tag[$];
    bit           obs_last[$];
    bit           prev_stall;
    logic [511:0] prev_data;
    logic         prev_last;
    bit           tog_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] cur_data();
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = f[i];
        return d;
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_data.delete(); exp_last.delete();
            open_tail = 0; pkt_cnt = 0; pkt_cfg = 0;
            mdl_beats = 0; mdl_pkts = 0; prev_stall = 0;
            chk("rst_in_ready", {511'd0, in_ready}, 512'd0);
            chk("rst_ctrl_ready", {511'd0, in_ctrl_ready}, 512'd0);
        end else begin
            chk("tkeep", {448'd0, m_axis_tkeep}, {448'd0, {64{1'b1}}});
            chk("in_ready", {511'd0, in_ready}, {511'd0, ~m_axis_tvalid | m_axis_tready});
            chk("ctrl_ready", {511'd0, in_ctrl_ready},
                {511'd0, (~m_axis_tvalid | m_axis_tready) & ~in_valid});
            chk("cnt_beats", {480'd0, cnt_beats}, {480'd0, mdl_beats});
            chk("cnt_pkts", {480'd0, cnt_pkts}, {480'd0, mdl_pkts});
            if (prev_stall) begin
                chk("stall_tvalid", {511'd0, m_axis_tvalid}, 512'd1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tlast", {511'd0, m_axis_tlast}, {511'd0, prev_last});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_beat", m_axis_tdata, 512'd0 ^ ~m_axis_tdata);
                end else begin
                    logic [511:0] ed;
                    bit el;
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    chk("beat_data", m_axis_tdata, ed);
                    chk("beat_last", {511'd0, m_axis_tlast}, {511'd0, el});
                    mdl_beats = mdl_beats + 1;
                    if (el) mdl_pkts = mdl_pkts + 1;
                end
                obs_tag.push_back(m_axis_tdata[63:0]);
                obs_last.push_back(m_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (in_valid && in_ready) begin
                bit l;
                if (pkt_cnt == 0) pkt_cfg = int'(cfg_pkt_beats);
                pkt_cnt++;
                l = (pkt_cfg != 0) && (pkt_cnt == pkt_cfg);
                if (l) pkt_cnt = 0;
                exp_data.push_back(cur_data());
                exp_last.push_back(l);
                open_tail = !l;
            end else if (in_ctrl_valid && in_ctrl_ready) begin
                if (open_tail) exp_last[exp_last.size()-1] = 1'b1;
                open_tail = 0;
                pkt_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
        if (tog_en) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; in_valid = 1'b0; in_ctrl_valid = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        obs_tag.delete(); obs_last.delete();
    endtask

    task automatic push_beat(input logic [63:0] tag);
        bit acc;
        f[0] = tag;
        for (int i = 1; i < 8; i++) f[i] = {$urandom, $urandom};
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk); acc = in_ready;
            tick();
            if (acc) break;
            if (n == 99) chk("push_timeout", 512'd1, 512'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_ctrl();
        bit acc;
        in_ctrl_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk); acc = in_ctrl_ready;
            tick();
            if (acc) break;
            if (n == 99) chk("ctrl_timeout", 512'd1, 512'd0);
        end
        in_ctrl_valid = 1'b0;
    endtask

    task automatic drain();
        tog_en = 1'b0; m_axis_tready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge aclk);
            if (exp_data.size() == 0 && !m_axis_tvalid) break;
        end
        tick();
        chk("drain_empty", 512'(exp_data.size()), 512'd0);
    endtask

    task automatic chk_lasts(input string name, input int n, input int l0, input int l1, input int l2);
        chk({name, "_count"}, 512'(obs_tag.size()), 512'(n));
        for (int i = 0; i < obs_tag.size(); i++) begin
            chk({name, "_tag"}, {448'd0, obs_tag[i]}, 512'(i + 1));
            chk({name, "_tlast"}, {511'd0, obs_last[i]}, {511'd0, (i == l0 || i == l1 || i == l2)});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc_d, acc_c;
        for (int i = 0; i < 8; i++) f[i] = '0;
        m_axis_tready = 1'b1; cfg_pkt_beats = 16'd0;
        do_reset();
        chk("reset_tvalid", {511'd0, m_axis_tvalid}, 512'd0);
        chk("reset_tdata", m_axis_tdata, 512'd0);
        chk("reset_cnt", {480'd0, cnt_beats}, 512'd0);

        // Fixed packets of 4 across 8 beats; trailing token adds nothing.
        cfg_pkt_beats = 16'd4;
        for (int i = 1; i <= 8; i++) push_beat(64'(i));
        send_ctrl(); drain();
        chk_lasts("pk4x8", 8, 3, 7, 7);
        chk("pk4x8_cnt_beats", {480'd0, cnt_beats}, 512'd8);
        chk("pk4x8_cnt_pkts", {480'd0, cnt_pkts}, 512'd2);

        // Unlimited packet closed only by the token.
        do_reset(); cfg_pkt_beats = 16'd0;
        for (int i = 1; i <= 3; i++) push_beat(64'(i));
        send_ctrl(); drain();
        chk_lasts("unlim", 3, 2, 2, 2);
        chk("unlim_cnt_pkts", {480'd0, cnt_pkts}, 512'd1);

        // Short packet via token, then a full packet proves beat_idx restarted.
        do_reset(); cfg_pkt_beats = 16'd4;
        for (int i = 1; i <= 6; i++) push_beat(64'(i));
        send_ctrl();
        for (int i = 7; i <= 10; i++) push_beat(64'(i));
        drain();
        chk_lasts("short", 10, 3, 5, 9);

        // Alternating backpressure.
        do_reset(); cfg_pkt_beats = 16'd4; m_axis_tready = 1'b1; tog_en = 1'b1;
        for (int i = 1; i <= 8; i++) push_beat(64'(i));
        send_ctrl(); drain();
        chk_lasts("stall", 8, 3, 7, 7);

        // Data and token offered together: data wins.
        do_reset(); cfg_pkt_beats = 16'd0;
        f[0] = 64'd1; in_valid = 1'b1; in_ctrl_valid = 1'b1;
        @(negedge aclk);
        chk("conflict_ctrl_ready", {511'd0, in_ctrl_ready}, 512'd0);
        chk("conflict_in_ready", {511'd0, in_ready}, 512'd1);
        tick(); in_valid = 1'b0;
        @(negedge aclk);
        chk("conflict_ctrl_after", {511'd0, in_ctrl_ready}, 512'd1);
        tick(); in_ctrl_valid = 1'b0;
        drain();
        chk_lasts("conflict", 1, 0, 0, 0);

        // Reset with both hold slot and output register occupied.
        do_reset(); cfg_pkt_beats = 16'd0; m_axis_tready = 1'b0;
        push_beat(64'd1); push_beat(64'd2);
        @(negedge aclk);
        chk("pre_rst_tvalid", {511'd0, m_axis_tvalid}, 512'd1);
        tick(); aresetn = 1'b0;
        tick();
        chk("mid_rst_tvalid", {511'd0, m_axis_tvalid}, 512'd0);
        chk("mid_rst_cnt", {480'd0, cnt_beats}, 512'd0);
        aresetn = 1'b1; m_axis_tready = 1'b1;
        obs_tag.delete(); obs_last.delete();
        repeat (20) tick();
        chk("post_rst_beats", 512'(obs_tag.size()), 512'd0);

        // Random traffic with random backpressure and packet sizes.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            acc_d = in_valid && in_ready;
            acc_c = in_ctrl_valid && in_ctrl_ready;
            tick();
            if (!in_valid || acc_d) begin
                in_valid = ($urandom % 4) != 0;
                for (int i = 0; i < 8; i++) f[i] = {$urandom, $urandom};
            end
            if (!in_ctrl_valid || acc_c) in_ctrl_valid = ($urandom % 16) == 0;
            m_axis_tready = ($urandom % 4) != 0;
            if ($urandom % 64 == 0) cfg_pkt_beats = 16'($urandom % 6);
        end
        in_valid = 1'b0; in_ctrl_valid = 1'b0;
        send_ctrl(); drain();
        chk("rand_model_beats", {480'd0, cnt_beats}, {480'd0, mdl_beats});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
